// File: rtl/apb_cmd_pkg.sv
// Shared types and constants for the APB command master.
package apb_cmd_pkg;

  localparam int APB_ADDR_MSB = 23;
  localparam int APB_ADDR_LSB = 2;
  localparam int APB_DATA_W   = 32;

  typedef logic [APB_ADDR_MSB:APB_ADDR_LSB] apb_addr_t;
  typedef logic [APB_DATA_W-1:0]            apb_data_t;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_state_e;

endpackage

// File: rtl/apb_cmd_master_if.sv
// Command/response stream plus APB bus signals of the command master.
interface apb_cmd_master_if;
  import apb_cmd_pkg::*;

  // command stream
  logic      cmd_valid;
  logic      cmd_ready;
  logic      cmd_write;
  apb_addr_t cmd_addr;
  apb_data_t cmd_wdata;

  // response stream
  logic      rsp_valid;
  logic      rsp_ready;
  apb_data_t rsp_rdata;
  logic      rsp_err;

  // APB bus
  apb_addr_t paddr;
  logic      pwrite;
  apb_data_t pwdata;
  logic      psel;
  logic      penable;
  logic      pready;
  apb_data_t prdata;

  // view of the command master itself
  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, pready, prdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output paddr, pwrite, pwdata, psel, penable
  );

  // view of the environment: command source, response sink and APB slave
  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, pready, prdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  paddr, pwrite, pwdata, psel, penable
  );

endinterface

// File: rtl/apb_timeout_ctr.sv
// Counts ACCESS wait cycles; expired flags that the limit has been reached.
// A limit of 0 disables the timeout entirely.
module apb_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      assign expired = 1'b0;
    end else begin : g_on
      localparam int W = $clog2(TIMEOUT_CYCLES + 1);
      localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES);

      logic [W-1:0] count_reg;

      // clear on transfer start, count wait cycles, never run past the limit
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          count_reg <= '0;
        end else if (clr) begin
          count_reg <= '0;
        end else if (inc && (count_reg != LIMIT)) begin
          count_reg <= count_reg + W'(1);
        end
      end

      assign expired = (count_reg == LIMIT);
    end
  endgenerate

endmodule

// File: rtl/apb_cmd_master.sv
// Single-outstanding APB master: one valid/ready command becomes one APB
// transfer, whose result lands in a one-entry response register.
module apb_cmd_master
  import apb_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              reset,
  apb_cmd_master_if.master  bus
);

  apb_state_e state_reg, state_next;
  apb_addr_t  paddr_reg, paddr_next;
  logic       pwrite_reg, pwrite_next;
  apb_data_t  pwdata_reg, pwdata_next;
  logic       psel_reg, psel_next;
  logic       penable_reg, penable_next;
  logic       rsp_valid_reg, rsp_valid_next;
  apb_data_t  rsp_rdata_reg, rsp_rdata_next;
  logic       rsp_err_reg, rsp_err_next;

  logic cmd_ready_int;
  logic ctr_clr;
  logic ctr_inc;
  logic ctr_expired;

  apb_timeout_ctr #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clr     (ctr_clr),
    .inc     (ctr_inc),
    .expired (ctr_expired)
  );

  // state register; psel/penable reset asynchronously so a reset kills the bus at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      paddr_reg     <= '0;
      pwrite_reg    <= 1'b0;
      pwdata_reg    <= '0;
      psel_reg      <= 1'b0;
      penable_reg   <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      paddr_reg     <= paddr_next;
      pwrite_reg    <= pwrite_next;
      pwdata_reg    <= pwdata_next;
      psel_reg      <= psel_next;
      penable_reg   <= penable_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_rdata_reg <= rsp_rdata_next;
      rsp_err_reg   <= rsp_err_next;
    end
  end

  // next-state, bus and response logic
  always_comb begin
    state_next     = state_reg;
    paddr_next     = paddr_reg;
    pwrite_next    = pwrite_reg;
    pwdata_next    = pwdata_reg;
    psel_next      = psel_reg;
    penable_next   = penable_reg;
    rsp_valid_next = rsp_valid_reg;
    rsp_rdata_next = rsp_rdata_reg;
    rsp_err_next   = rsp_err_reg;
    cmd_ready_int  = 1'b0;
    ctr_clr        = 1'b0;
    ctr_inc        = 1'b0;

    // a draining response frees the register in the same cycle
    if (rsp_valid_reg && bus.rsp_ready) begin
      rsp_valid_next = 1'b0;
    end

    case (state_reg)
      IDLE: begin
        cmd_ready_int = !rsp_valid_reg || bus.rsp_ready;
        if (bus.cmd_valid && cmd_ready_int) begin
          paddr_next   = bus.cmd_addr;
          pwrite_next  = bus.cmd_write;
          pwdata_next  = bus.cmd_wdata;
          psel_next    = 1'b1;
          penable_next = 1'b0;
          ctr_clr      = 1'b1;
          state_next   = SETUP;
        end
      end
      SETUP: begin
        penable_next = 1'b1;
        state_next   = ACCESS;
      end
      ACCESS: begin
        // pready wins over a timeout reached in the same cycle
        if (bus.pready) begin
          rsp_valid_next = 1'b1;
          rsp_rdata_next = pwrite_reg ? '0 : bus.prdata;
          rsp_err_next   = 1'b0;
          psel_next      = 1'b0;
          penable_next   = 1'b0;
          state_next     = IDLE;
        end else if (ctr_expired) begin
          rsp_valid_next = 1'b1;
          rsp_rdata_next = '0;
          rsp_err_next   = 1'b1;
          psel_next      = 1'b0;
          penable_next   = 1'b0;
          state_next     = IDLE;
        end else begin
          ctr_inc = 1'b1;
        end
      end
      default: begin
        psel_next    = 1'b0;
        penable_next = 1'b0;
        state_next   = IDLE;
      end
    endcase
  end

  assign bus.cmd_ready = cmd_ready_int;
  assign bus.paddr     = paddr_reg;
  assign bus.pwrite    = pwrite_reg;
  assign bus.pwdata    = pwdata_reg;
  assign bus.psel      = psel_reg;
  assign bus.penable   = penable_reg;
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_rdata = rsp_rdata_reg;
  assign bus.rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Self-checking bench for apb_cmd_master with a small APB slave model and
// a response scoreboard.
module tb_apb_cmd_master;
  import apb_cmd_pkg::*;

  localparam int unsigned TO_CYCLES = 4;
  localparam int WAIT_BOUND = 50;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  rsp_t exp_q[$];

  // slave model controls
  int          wait_cfg = 0;
  logic        no_ready = 1'b0;
  int          acc_cnt = 0;
  logic [31:0] slave_rdata = 32'h0;

  apb_cmd_master_if bus ();

  apb_cmd_master #(
    .TIMEOUT_CYCLES (TO_CYCLES)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // slave asserts pready after wait_cfg ACCESS wait cycles, or never
  always_comb bus.pready = !no_ready && bus.psel && bus.penable && (acc_cnt == wait_cfg);
  assign bus.prdata = slave_rdata;

  always @(posedge clk) begin
    if (bus.psel && bus.penable && !bus.pready) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end

  // present one command and let it be taken at the next edge
  task automatic issue(input logic wr, input apb_addr_t addr, input logic [31:0] data);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = data;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  // wait (bounded) for rsp_valid; returns cycles waited
  task automatic wait_rsp(output int cycles);
    cycles = 0;
    while (!bus.rsp_valid && cycles < WAIT_BOUND) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic drain();
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    checks++;
    if ({bus.psel, bus.penable, bus.pwrite, bus.rsp_valid, bus.rsp_err} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b want=00000", {bus.psel, bus.penable, bus.pwrite, bus.rsp_valid, bus.rsp_err});
    end
    checks++;
    if (bus.paddr !== '0 || bus.pwdata !== '0 || bus.rsp_rdata !== '0) begin
      failures++;
      $display("FAIL reset_data paddr=%h pwdata=%h rdata=%h want all 0", bus.paddr, bus.pwdata, bus.rsp_rdata);
    end
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_cmd_ready got=%b want=1", bus.cmd_ready);
    end
    $display("reset: checked idle state");
  endtask

  task automatic test_write();
    rsp_t e;
    int   cyc;
    wait_cfg = 0;
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL wr_cmd_ready got=%b want=1", bus.cmd_ready);
    end
    exp_q.push_back('{rdata: 32'h0, err: 1'b0});
    issue(1'b1, 22'h000010, 32'hDEADBEEF);
    checks++;
    if (bus.psel !== 1'b1 || bus.penable !== 1'b0 || bus.paddr !== 22'h10 || bus.pwrite !== 1'b1
        || bus.pwdata !== 32'hDEADBEEF || bus.cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL wr_setup psel=%b pen=%b paddr=%h pwrite=%b pwdata=%h rdy=%b want 1 0 10 1 deadbeef 0",
               bus.psel, bus.penable, bus.paddr, bus.pwrite, bus.pwdata, bus.cmd_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.psel !== 1'b1 || bus.penable !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL wr_access psel=%b pen=%b rsp_valid=%b want 1 1 0", bus.psel, bus.penable, bus.rsp_valid);
    end
    wait_rsp(cyc);
    checks++;
    if (cyc !== 1) begin
      failures++;
      $display("FAIL wr_latency got=%0d want=1 cycle after ACCESS", cyc);
    end
    e = exp_q.pop_front();
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== e.rdata || bus.rsp_err !== e.err || bus.psel !== 1'b0) begin
      failures++;
      $display("FAIL wr_rsp valid=%b rdata=%h err=%b psel=%b want 1 %h %b 0",
               bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.psel, e.rdata, e.err);
    end
    drain();
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL wr_drain rsp_valid=%b want=0", bus.rsp_valid);
    end
    $display("write: addr=10 data=deadbeef rsp rdata=%h err=%b", e.rdata, e.err);
  endtask

  task automatic test_read_wait();
    rsp_t e;
    int   pen_cnt;
    int   cyc;
    logic addr_ok;
    wait_cfg = 3;
    slave_rdata = 32'h12345678;
    exp_q.push_back('{rdata: 32'h12345678, err: 1'b0});
    issue(1'b0, 22'h3ABCD, 32'hFFFF0000);
    pen_cnt = 0;
    cyc = 0;
    addr_ok = 1'b1;
    while (!bus.rsp_valid && cyc < WAIT_BOUND) begin
      if (bus.paddr !== 22'h3ABCD || bus.pwrite !== 1'b0) addr_ok = 1'b0;
      @(posedge clk); #1;
      if (bus.penable) pen_cnt++;
      cyc++;
    end
    checks++;
    if (pen_cnt !== 4 || cyc >= WAIT_BOUND) begin
      failures++;
      $display("FAIL rd_penable_cycles got=%0d want=4", pen_cnt);
    end
    checks++;
    if (!addr_ok) begin
      failures++;
      $display("FAIL rd_addr_stable got=unstable want=3abcd held");
    end
    e = exp_q.pop_front();
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== e.rdata || bus.rsp_err !== e.err) begin
      failures++;
      $display("FAIL rd_rsp valid=%b rdata=%h err=%b want 1 %h %b", bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, e.rdata, e.err);
    end
    drain();
    wait_cfg = 0;
    $display("read: addr=3abcd waits=3 rsp rdata=%h err=%b", e.rdata, e.err);
  endtask

  task automatic test_timeout();
    rsp_t e;
    int   acc;
    int   cyc;
    no_ready = 1'b1;
    exp_q.push_back('{rdata: 32'h0, err: 1'b1});
    issue(1'b0, 22'h20, 32'h0);
    slave_rdata = 32'hCAFEF00D;
    acc = 0;
    cyc = 0;
    while (bus.psel && cyc < WAIT_BOUND) begin
      @(posedge clk); #1;
      if (bus.penable) acc++;
      cyc++;
    end
    checks++;
    if (acc !== 5 || cyc >= WAIT_BOUND) begin
      failures++;
      $display("FAIL to_access_cycles got=%0d want=5", acc);
    end
    e = exp_q.pop_front();
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== e.err || bus.rsp_rdata !== e.rdata) begin
      failures++;
      $display("FAIL to_rsp valid=%b err=%b rdata=%h want 1 %b %h", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, e.err, e.rdata);
    end
    drain();
    no_ready = 1'b0;
    slave_rdata = 32'hA5A50001;
    exp_q.push_back('{rdata: 32'hA5A50001, err: 1'b0});
    issue(1'b0, 22'h24, 32'h0);
    wait_rsp(cyc);
    e = exp_q.pop_front();
    checks++;
    if (cyc >= WAIT_BOUND || bus.rsp_rdata !== e.rdata || bus.rsp_err !== e.err) begin
      failures++;
      $display("FAIL to_followup rdata=%h err=%b want %h %b", bus.rsp_rdata, bus.rsp_err, e.rdata, e.err);
    end
    drain();
    $display("timeout: abort after 5 ACCESS cycles, follow-up read rdata=%h", e.rdata);
  endtask

  task automatic test_backpressure();
    rsp_t e;
    int   cyc;
    int   bad_rdy;
    int   bad_rsp;
    bus.rsp_ready = 1'b0;
    exp_q.push_back('{rdata: 32'h0, err: 1'b0});
    issue(1'b1, 22'h40, 32'h11112222);
    wait_rsp(cyc);
    checks++;
    if (cyc >= WAIT_BOUND) begin
      failures++;
      $display("FAIL bp_first_rsp got=timeout want=rsp_valid");
    end
    slave_rdata = 32'h0BADF00D;
    exp_q.push_back('{rdata: 32'h0BADF00D, err: 1'b0});
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 22'h44;
    bus.cmd_wdata = 32'h0;
    bad_rdy = 0;
    bad_rsp = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.cmd_ready !== 1'b0 || bus.psel !== 1'b0) bad_rdy++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== exp_q[0].rdata || bus.rsp_err !== exp_q[0].err) bad_rsp++;
    end
    checks++;
    if (bad_rdy != 0) begin
      failures++;
      $display("FAIL bp_cmd_ready bad_cycles=%0d want=0", bad_rdy);
    end
    checks++;
    if (bad_rsp != 0) begin
      failures++;
      $display("FAIL bp_rsp_held bad_cycles=%0d want=0", bad_rsp);
    end
    bus.rsp_ready = 1'b1;
    #1;
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_same_cycle_ready got=%b want=1", bus.cmd_ready);
    end
    e = exp_q.pop_front();
    checks++;
    if (bus.rsp_rdata !== e.rdata || bus.rsp_err !== e.err) begin
      failures++;
      $display("FAIL bp_rsp1 rdata=%h err=%b want %h %b", bus.rsp_rdata, bus.rsp_err, e.rdata, e.err);
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    checks++;
    if (bus.psel !== 1'b1 || bus.penable !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.paddr !== 22'h44) begin
      failures++;
      $display("FAIL bp_accept psel=%b pen=%b rsp_valid=%b paddr=%h want 1 0 0 44",
               bus.psel, bus.penable, bus.rsp_valid, bus.paddr);
    end
    wait_rsp(cyc);
    e = exp_q.pop_front();
    checks++;
    if (cyc >= WAIT_BOUND || bus.rsp_rdata !== e.rdata || bus.rsp_err !== e.err) begin
      failures++;
      $display("FAIL bp_rsp2 rdata=%h err=%b want %h %b", bus.rsp_rdata, bus.rsp_err, e.rdata, e.err);
    end
    drain();
    $display("backpressure: held 10 cycles, queued read rdata=%h", e.rdata);
  endtask

  task automatic test_reset_mid();
    int bad;
    no_ready = 1'b1;
    issue(1'b1, 22'h80, 32'h55AA55AA);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.psel !== 1'b0 || bus.penable !== 1'b0) begin
      failures++;
      $display("FAIL rst_async psel=%b pen=%b want 0 0", bus.psel, bus.penable);
    end
    no_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_cmd_ready got=%b want=1", bus.cmd_ready);
    end
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (bus.rsp_valid !== 1'b0 || bus.psel !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL rst_no_rsp bad_cycles=%0d want=0", bad);
    end
    $display("reset_mid: bus dropped, no response");
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;
    test_reset();
    @(posedge clk); #1;
    test_write();
    test_read_wait();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
